// File: rtl/aes_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_round_ctrl                                               |
// | Description : AES-128 round sequencer driving the malch datapath: operand  |
// |               muxing, cs/count decode and ciphertext capture.              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module aes_round_ctrl #(
    parameter int NR    = 10,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [127:0]     pt_in,
    input  logic [127:0]     key_in,
    input  logic [127:0]     dp_out,
    input  logic [127:0]     dp_exkey,
    output logic [127:0]     dp_in,
    output logic [127:0]     dp_key,
    output logic [2:0]       cs,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [127:0]     ct_out
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADD0 = 3'd1;
    localparam logic [2:0] S_SUB  = 3'd2;
    localparam logic [2:0] S_SHI  = 3'd3;
    localparam logic [2:0] S_MIX  = 3'd4;
    localparam logic [2:0] S_ADDR = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;

    localparam logic [2:0] CS_RES = 3'b000;
    localparam logic [2:0] CS_ADD = 3'b001;
    localparam logic [2:0] CS_SUB = 3'b010;
    localparam logic [2:0] CS_SHI = 3'b100;
    localparam logic [2:0] CS_MIX = 3'b101;
    localparam logic [2:0] CS_FIN = 3'b111;

    localparam logic [3:0] C_LAST_ROUND = 4'(NR);

    logic [2:0]   state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic         done_q,  done_d;
    logic [127:0] ct_q,    ct_d;
    logic         w_last_round;

    assign w_last_round = (round_q == C_LAST_ROUND);

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        done_d  = 1'b0;
        ct_d    = ct_q;
        case (state_q)
            S_IDLE: begin
                round_d = 4'd0;
                if (start) begin
                    state_d = S_ADD0;
                end
            end
            S_ADD0: begin
                state_d = S_SUB;
                round_d = 4'd1;
            end
            S_SUB: begin
                state_d = S_SHI;
            end
            // The final round omits MixColumns.
            S_SHI: begin
                state_d = w_last_round ? S_ADDR : S_MIX;
            end
            S_MIX: begin
                state_d = S_ADDR;
            end
            S_ADDR: begin
                if (w_last_round) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_SUB;
                    round_d = round_q + 4'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                round_d = 4'd0;
                done_d  = 1'b1;
                ct_d    = dp_out;
            end
            default: begin
                state_d = S_IDLE;
                round_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            done_q  <= 1'b0;
            ct_q    <= 128'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            done_q  <= done_d;
            ct_q    <= ct_d;
        end
    end

    // Decode purely from registered state so start has no path to cs/count.
    always_comb begin
        cs = CS_RES;
        case (state_q)
            S_IDLE:  cs = CS_RES;
            S_ADD0:  cs = CS_ADD;
            S_SUB:   cs = CS_SUB;
            S_SHI:   cs = CS_SHI;
            S_MIX:   cs = CS_MIX;
            S_ADDR:  cs = CS_ADD;
            S_FIN:   cs = CS_FIN;
            default: cs = CS_RES;
        endcase
    end

    assign count  = CNT_W'(round_q);
    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign ct_out = ct_q;

    // In IDLE malch sees RES, so it reloads pt/key every edge including the accepting one.
    assign dp_in  = (state_q == S_IDLE) ? pt_in  : dp_out;
    assign dp_key = (state_q == S_IDLE) ? key_in : dp_exkey;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_aes_round_ctrl                                            |
// | Description : Bench for aes_round_ctrl with a behavioural malch and AES    |
// |               reference model.                                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_aes_round_ctrl;

    localparam int NR  = 10;
    localparam int LAT = 4 * NR + 1;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         start  = 1'b0;
    logic [127:0] pt_in  = '0;
    logic [127:0] key_in = '0;
    logic [127:0] m_out, m_key;
    logic [127:0] dp_in, dp_key, ct_out;
    logic [2:0]   cs;
    logic [7:0]   count;
    logic         busy, done;

    int errors = 0;
    int checks = 0;

    logic [7:0] sbox [256];

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(NR), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pt_in    (pt_in),
        .key_in   (key_in),
        .dp_out   (m_out),
        .dp_exkey (m_key),
        .dp_in    (dp_in),
        .dp_key   (dp_key),
        .cs       (cs),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .ct_out   (ct_out)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox[gb(s, i)];
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(c*4+w) -: 8] = gb(s, ((c + w) % 4) * 4 + w);
        return r;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] r = '0;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, c*4); a1 = gb(s, c*4+1); a2 = gb(s, c*4+2); a3 = gb(s, c*4+3);
            r[127-8*(c*4)   -: 8] = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
            r[127-8*(c*4+1) -: 8] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
            r[127-8*(c*4+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
            r[127-8*(c*4+3) -: 8] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
        return r;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input int rnd);
        logic [7:0]  rc = 8'h01;
        logic [31:0] w3, t, n0, n1, n2, n3;
        for (int i = 1; i < rnd; i++) rc = xt(rc);
        w3 = k[31:0];
        t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = w3        ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s = pt ^ key;
        logic [127:0] k = key;
        for (int r = 1; r <= NR; r++) begin
            k = next_key(k, r);
            s = shift_rows(sub_bytes(s));
            if (r < NR) s = mix_cols(s);
            s = s ^ k;
        end
        return s;
    endfunction

    // Expected {cs, count, busy} during cycle c of an encryption (c=1 is ADD0).
    function automatic logic [11:0] exp_trace(input int c);
        int j, r, p;
        if (c == 1) return {3'b001, 8'd0, 1'b1};
        if (c == LAT) return {3'b111, 8'(NR), 1'b1};
        j = c - 2; r = j / 4 + 1; p = j % 4;
        if (p == 0) return {3'b010, 8'(r), 1'b1};
        if (p == 1) return {3'b100, 8'(r), 1'b1};
        if (p == 2 && r < NR) return {3'b101, 8'(r), 1'b1};
        return {3'b001, 8'(r), 1'b1};
    endfunction

    // Behavioural malch datapath.
    always @(posedge clk) begin
        case (cs)
            3'b000: begin m_out <= dp_in;                  m_key <= dp_key; end
            3'b001: begin m_out <= dp_in ^ dp_key;         m_key <= dp_key; end
            3'b010: begin m_out <= sub_bytes(dp_in);       m_key <= dp_key; end
            3'b100: begin m_out <= shift_rows(dp_in);      m_key <= next_key(dp_key, int'(count)); end
            3'b101: begin m_out <= mix_cols(dp_in);        m_key <= dp_key; end
            default: begin m_out <= m_out;                 m_key <= m_key; end
        endcase
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [127:0] p, input logic [127:0] k);
        pt_in  = p;
        key_in = k;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input bit trace, input int poke_a, input int poke_b, output int lat);
        int n = 0;
        lat = -1;
        while (n <= LAT + 20) begin
            if (done) begin
                lat = n;
                break;
            end
            if (trace) begin
                chk($sformatf("trace_c%0d", n + 1), 128'({cs, count, busy}), 128'(exp_trace(n + 1)));
                if (n == 9) begin
                    chk("mux_in", dp_in, m_out);
                    chk("mux_key", dp_key, m_key);
                end
            end
            start = (n + 1 == poke_a) || (n + 1 == poke_b);
            if (start) begin
                pt_in  = {4{$urandom}};
                key_in = {4{$urandom}};
            end
            tick();
            n++;
        end
        start = 1'b0;
    endtask

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        int lat;
        int seen;
        logic [127:0] rp, rk;
        logic [7:0] inv;

        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end

        repeat (2) tick();
        chk("reset_state", 128'({cs, count, busy, done}), 128'd0);
        chk("reset_ct", ct_out, 128'd0);
        pt_in = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        #1;
        chk("idle_mux", dp_in, pt_in);
        rst_n = 1'b1;
        tick();

        // FIPS-197 C.1
        launch(C1_PT, C1_KEY);
        wait_done(1'b0, -1, -1, lat);
        chk("c1_latency", 128'(lat), 128'(LAT));
        chk("c1_ct", ct_out, C1_CT);
        tick();
        chk("done_one_cycle", 128'({done, busy}), 128'd0);
        chk("ct_hold", ct_out, C1_CT);

        // FIPS-197 B with per-cycle trace, then back-to-back C.1 from the done cycle
        launch(B_PT, B_KEY);
        wait_done(1'b1, -1, -1, lat);
        chk("b_latency", 128'(lat), 128'(LAT));
        chk("b_ct", ct_out, B_CT);
        chk("gap_busy_done", 128'({busy, done, cs}), 128'({1'b0, 1'b1, 3'b000}));
        launch(C1_PT, C1_KEY);
        chk("b2b_busy", 128'(busy), 128'd1);
        wait_done(1'b0, -1, -1, lat);
        chk("b2b_latency", 128'(lat), 128'(LAT));
        chk("b2b_ct", ct_out, C1_CT);
        tick();

        // Starts during a run must be ignored
        launch(B_PT, B_KEY);
        wait_done(1'b0, 5, 20, lat);
        chk("ign_latency", 128'(lat), 128'(LAT));
        chk("ign_ct", ct_out, B_CT);
        seen = 0;
        repeat (4) begin
            tick();
            if (busy || done) seen++;
        end
        chk("ign_no_queue", 128'(seen), 128'd0);

        // Asynchronous reset mid-encryption
        launch({4{$urandom}}, {4{$urandom}});
        repeat (16) tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 128'({cs, count, busy, done}), 128'd0);
        chk("async_rst_ct", ct_out, 128'd0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (50) begin
            tick();
            if (done || busy) seen++;
        end
        chk("rst_no_done", 128'(seen), 128'd0);
        launch(C1_PT, C1_KEY);
        wait_done(1'b0, -1, -1, lat);
        chk("post_rst_latency", 128'(lat), 128'(LAT));
        chk("post_rst_ct", ct_out, C1_CT);

        // Random scoreboard, launched back-to-back from each done cycle
        for (int i = 0; i < 1000; i++) begin
            rp = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom};
            launch(rp, rk);
            wait_done(1'b0, -1, -1, lat);
            chk($sformatf("rnd%0d_latency", i), 128'(lat), 128'(LAT));
            chk($sformatf("rnd%0d_ct", i), ct_out, aes_ref(rp, rk));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
